// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop
// serialiser timed by an internal bit-period counter.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 868,
    parameter int ADDR_W     = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic              tx
);

    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q;
    logic              push, pop;

    state_e            state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              bit_end;
    logic [7:0]        head;

    // count never exceeds DEPTH, so its top bit alone means full
    assign full     = cnt_q[ADDR_W];
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign overflow = ovf_q;
    assign push     = wr_en & ~full;
    assign head     = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
            ovf_q <= wr_en & full;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign bit_end = (timer_q == 16'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 16'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7)
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            shift_d = head;
            par_d   = (^head) ^ ODD;
        end
    end

    // tx is driven from the next state so the line changes on the entering edge
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign tx   = tx_q;

endmodule
